// File: rtl/alu_seq_acc.sv
// alu_seq_acc: registered ALU with an accumulator, an iterative shift-add
// multiplier and valid/ready handshakes on both sides. One op in flight.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   in_valid / in_ready   request handshake (in_ready only in IDLE)
//   op                    000 ADD 001 SUB 010 AND 011 OR 100 XOR
//                         101 SHL 110 SHR 111 MUL (unsigned)
//   acc_mode              take operand A from the accumulator instead of a
//   a, b                  operands; shifts use b[SHW-1:0]
//   acc_clr               synchronous accumulator clear (wins over load)
//   out_valid / out_ready result handshake (out_valid only in DONE)
//   result, zero, carry,  registered result and flags, held while DONE
//   neg, ovf
//   acc_out               accumulator register
//   busy                  multiplier iterating
module alu_seq_acc #(
    parameter  int WIDTH = 8,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic             acc_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             neg,
    output logic             ovf,
    output logic [WIDTH-1:0] acc_out,
    output logic             busy
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0]   acc_q;
    logic [WIDTH-1:0]   res_q;
    logic               zero_q, carry_q, neg_q, ovf_q;
    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [2*WIDTH-1:0] prod_q;
    logic [SHW-1:0]     cnt_q;

    logic               accept;
    logic               mul_last;
    logic [WIDTH-1:0]   a_sel;
    logic [SHW-1:0]     sh;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_c, alu_v;
    logic [2*WIDTH-1:0] prod_nxt;
    logic               fin_load;
    logic [WIDTH-1:0]   fin_res;
    logic               fin_c, fin_v;

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q == S_BUSY);
    assign result    = res_q;
    assign zero      = zero_q;
    assign carry     = carry_q;
    assign neg       = neg_q;
    assign ovf       = ovf_q;
    assign acc_out   = acc_q;

    assign accept   = in_valid && in_ready;
    // The WIDTH-th iteration is the one that completes the product.
    assign mul_last = (state_q == S_BUSY) && (cnt_q == SHW'(WIDTH - 1));
    assign a_sel    = acc_mode ? acc_q : a;
    assign sh       = b[SHW-1:0];
    assign prod_nxt = prod_q + (mplier_q[0] ? mcand_q : '0);

    // Single-cycle ALU on the live inputs; only sampled on the accept edge.
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op)
            OP_ADD: begin
                {alu_c, alu_res} = {1'b0, a_sel} + {1'b0, b};
                alu_v = (a_sel[WIDTH-1] == b[WIDTH-1]) &&
                        (alu_res[WIDTH-1] != a_sel[WIDTH-1]);
            end
            OP_SUB: begin
                // Bit WIDTH of the extended difference is the borrow.
                {alu_c, alu_res} = {1'b0, a_sel} - {1'b0, b};
                alu_v = (a_sel[WIDTH-1] != b[WIDTH-1]) &&
                        (alu_res[WIDTH-1] != a_sel[WIDTH-1]);
            end
            OP_AND: alu_res = a_sel & b;
            OP_OR:  alu_res = a_sel | b;
            OP_XOR: alu_res = a_sel ^ b;
            // An extra guard bit catches the last bit shifted out; a zero
            // shift leaves it clear.
            OP_SHL: {alu_c, alu_res} = {1'b0, a_sel} << sh;
            OP_SHR: {alu_res, alu_c} = {a_sel, 1'b0} >> sh;
            default: ;
        endcase
    end

    // Value registered on the edge that enters DONE.
    always_comb begin
        fin_load = 1'b0;
        fin_res  = alu_res;
        fin_c    = alu_c;
        fin_v    = alu_v;
        if (mul_last) begin
            fin_load = 1'b1;
            fin_res  = prod_nxt[WIDTH-1:0];
            fin_c    = |prod_nxt[2*WIDTH-1:WIDTH];
            fin_v    = 1'b0;
        end else if (accept && op != OP_MUL) begin
            fin_load = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept)    state_d = (op == OP_MUL) ? S_BUSY : S_DONE;
            S_BUSY: if (mul_last)  state_d = S_DONE;
            S_DONE: if (out_ready) state_d = S_IDLE;
            default:               state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_q    <= '0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
            neg_q    <= 1'b0;
            ovf_q    <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
        end else begin
            if (accept && op == OP_MUL) begin
                mcand_q  <= {{WIDTH{1'b0}}, a_sel};
                mplier_q <= b;
                prod_q   <= '0;
                cnt_q    <= '0;
            end
            if (state_q == S_BUSY) begin
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                prod_q   <= prod_nxt;
                cnt_q    <= cnt_q + SHW'(1);
            end
            if (fin_load) begin
                res_q   <= fin_res;
                zero_q  <= (fin_res == '0);
                carry_q <= fin_c;
                neg_q   <= fin_res[WIDTH-1];
                ovf_q   <= fin_v;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)           acc_q <= '0;
        else if (acc_clr)  acc_q <= '0;
        else if (fin_load) acc_q <= fin_res;
    end

endmodule

// File: tb/tb_alu_seq_acc.sv
// Bench for alu_seq_acc (WIDTH=8): a vector table, hand sequences for the
// multi-cycle corners, then random ops against an arithmetic reference model.
module tb_alu_seq_acc;

    logic       clk = 1'b0;
    logic       rst, in_valid, in_ready, acc_mode, acc_clr;
    logic       out_valid, out_ready, zero, carry, neg, ovf, busy;
    logic [2:0] op;
    logic [7:0] a, b, result, acc_out;

    int pass_cnt = 0;
    int total_cnt = 0;
    logic [7:0] acc_m = 8'h00;

    alu_seq_acc #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .acc_mode(acc_mode), .a(a), .b(b), .acc_clr(acc_clr),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .zero(zero), .carry(carry), .neg(neg), .ovf(ovf),
        .acc_out(acc_out), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    typedef struct {
        logic [7:0] res;
        logic       c;
        logic       v;
    } exp_t;

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       clr;
        int         hold;
        logic [7:0] res;
        logic       c;
        logic       v;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        else pass_cnt++;
    endtask

    // Reference: plain integer arithmetic, signed range checks for overflow.
    function automatic exp_t ref_op(input int o, input int x, input int y);
        exp_t e;
        int sx, sy, t, s;
        sx = (x > 127) ? x - 256 : x;
        sy = (y > 127) ? y - 256 : y;
        s  = y % 8;
        e.c = 1'b0;
        e.v = 1'b0;
        case (o)
            0: begin t = x + y; e.c = (t > 255); e.v = (sx + sy > 127) || (sx + sy < -128); end
            1: begin t = x - y; e.c = (x < y);   e.v = (sx - sy > 127) || (sx - sy < -128); end
            2: t = x & y;
            3: t = x | y;
            4: t = x ^ y;
            5: begin t = x << s; e.c = (s != 0) && (((x >> (8 - s)) & 1) == 1); end
            6: begin t = x >> s; e.c = (s != 0) && (((x >> (s - 1)) & 1) == 1); end
            default: begin t = x * y; e.c = (t > 255); end
        endcase
        e.res = t[7:0];
        return e;
    endfunction

    // Issue one op from IDLE, wait for the result, check it, hold for
    // 'hold' cycles with junk requests pending, then release.
    task automatic run_op(input string nm, input logic [2:0] o, input logic am,
                          input logic [7:0] aa, input logic [7:0] bb,
                          input logic clr, input int hold, input exp_t e);
        int lat, bc, rb;
        logic [7:0] acc_exp;
        chk({nm, ".in_ready"}, in_ready, 1);
        op = o; acc_mode = am; a = aa; b = bb; acc_clr = clr; in_valid = 1'b1;
        @(posedge clk); #1;
        acc_clr = 1'b0;
        op = 3'($urandom); a = 8'($urandom); b = 8'($urandom); acc_mode = 1'($urandom);
        lat = 1; bc = 0; rb = 0;
        while (!out_valid && lat < 40) begin
            if (busy) bc++;
            if (in_ready) rb++;
            @(posedge clk); #1;
            lat++;
        end
        acc_exp = (clr && o != 3'd7) ? 8'h00 : e.res;
        acc_m = acc_exp;
        chk({nm, ".latency"}, lat, (o == 3'd7) ? 9 : 1);
        chk({nm, ".busy_cycles"}, bc, (o == 3'd7) ? 8 : 0);
        chk({nm, ".ready_while_busy"}, rb, 0);
        chk({nm, ".result"}, result, e.res);
        chk({nm, ".carry"}, carry, e.c);
        chk({nm, ".ovf"}, ovf, e.v);
        chk({nm, ".zero"}, zero, e.res == 8'h00);
        chk({nm, ".neg"}, neg, e.res[7]);
        chk({nm, ".acc_out"}, acc_out, acc_exp);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk({nm, ".held_result"}, {out_valid, in_ready, result}, {1'b1, 1'b0, e.res});
            chk({nm, ".held_acc"}, acc_out, acc_exp);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({nm, ".release"}, {out_valid, in_ready}, 2'b01);
    endtask

    task automatic clr_pulse(input string nm);
        acc_clr = 1'b1;
        @(posedge clk); #1;
        acc_clr = 1'b0;
        acc_m = 8'h00;
        chk({nm, ".acc_clr"}, acc_out, 0);
    endtask

    function automatic exp_t mk(input logic [7:0] r, input logic c, input logic v);
        exp_t e;
        e.res = r; e.c = c; e.v = v;
        return e;
    endfunction

    vec_t vt [16];

    initial begin
        int ov, lat;
        exp_t e;
        logic [7:0] ra, rb8, aop;
        logic [2:0] ro;
        logic ram, rclr;

        vt[0]  = '{3'd0, 8'hF0, 8'h20, 1'b0, 0, 8'h10, 1'b1, 1'b0};
        vt[1]  = '{3'd1, 8'h80, 8'h01, 1'b0, 0, 8'h7F, 1'b0, 1'b1};
        vt[2]  = '{3'd1, 8'h05, 8'h05, 1'b0, 0, 8'h00, 1'b0, 1'b0};
        vt[3]  = '{3'd7, 8'h10, 8'h11, 1'b0, 0, 8'h10, 1'b1, 1'b0};
        vt[4]  = '{3'd7, 8'h0F, 8'h0F, 1'b0, 0, 8'hE1, 1'b0, 1'b0};
        vt[5]  = '{3'd4, 8'hAA, 8'hFF, 1'b0, 5, 8'h55, 1'b0, 1'b0};
        vt[6]  = '{3'd2, 8'hF0, 8'h3C, 1'b0, 0, 8'h30, 1'b0, 1'b0};
        vt[7]  = '{3'd3, 8'hF0, 8'h0F, 1'b0, 1, 8'hFF, 1'b0, 1'b0};
        vt[8]  = '{3'd5, 8'h81, 8'h01, 1'b0, 0, 8'h02, 1'b1, 1'b0};
        vt[9]  = '{3'd6, 8'h81, 8'h01, 1'b0, 0, 8'h40, 1'b1, 1'b0};
        vt[10] = '{3'd6, 8'h81, 8'h00, 1'b0, 0, 8'h81, 1'b0, 1'b0};
        vt[11] = '{3'd5, 8'h01, 8'h07, 1'b0, 0, 8'h80, 1'b0, 1'b0};
        vt[12] = '{3'd0, 8'h7F, 8'h01, 1'b0, 0, 8'h80, 1'b0, 1'b1};
        vt[13] = '{3'd7, 8'hFF, 8'hFF, 1'b0, 0, 8'h01, 1'b1, 1'b0};
        vt[14] = '{3'd1, 8'h00, 8'h01, 1'b0, 0, 8'hFF, 1'b1, 1'b0};
        vt[15] = '{3'd0, 8'h01, 8'h02, 1'b1, 0, 8'h03, 1'b0, 1'b0};

        rst = 1'b1; in_valid = 1'b0; acc_mode = 1'b0; acc_clr = 1'b0;
        out_ready = 1'b0; op = 3'd0; a = 8'h00; b = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("reset.ctl", {in_ready, out_valid, busy}, 3'b100);
        chk("reset.flags", {zero, carry, neg, ovf}, 4'b0000);
        chk("reset.result", result, 0);
        chk("reset.acc", acc_out, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 16; i++)
            run_op($sformatf("vec%0d", i), vt[i].op, 1'b0, vt[i].a, vt[i].b,
                   vt[i].clr, vt[i].hold, mk(vt[i].res, vt[i].c, vt[i].v));

        // Accumulate chain
        clr_pulse("chain");
        run_op("chain.add1", 3'd0, 1'b1, 8'hEE, 8'h03, 1'b0, 0, mk(8'h03, 1'b0, 1'b0));
        run_op("chain.add2", 3'd0, 1'b1, 8'h11, 8'h03, 1'b0, 0, mk(8'h06, 1'b0, 1'b0));
        run_op("chain.add3", 3'd0, 1'b1, 8'h77, 8'h03, 1'b0, 0, mk(8'h09, 1'b0, 1'b0));
        // 0x09 << 5: the last bit shifted out is bit 3, which is set.
        run_op("chain.shl_acc", 3'd5, 1'b1, 8'h00, 8'h05, 1'b0, 0, mk(8'h20, 1'b1, 1'b0));
        run_op("chain.shl_a", 3'd5, 1'b0, 8'h81, 8'h01, 1'b0, 0, mk(8'h02, 1'b1, 1'b0));

        // acc_clr in the middle of a MUL; the MUL still loads at completion
        op = 3'd7; acc_mode = 1'b0; a = 8'h03; b = 8'h05; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        acc_clr = 1'b1;
        @(posedge clk); #1;
        acc_clr = 1'b0;
        chk("busyclr.acc", {busy, acc_out}, {1'b1, 8'h00});
        lat = 0;
        while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
        chk("busyclr.result", {out_valid, result}, {1'b1, 8'h0F});
        chk("busyclr.acc_load", acc_out, 8'h0F);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        acc_m = 8'h0F;
        run_op("pre_rst", 3'd0, 1'b1, 8'h00, 8'h01, 1'b0, 0, mk(8'h10, 1'b0, 1'b0));

        // Asynchronous reset during cycle 4 of a MUL
        op = 3'd7; a = 8'h10; b = 8'h11; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("midrst.ctl", {in_ready, out_valid, busy}, 3'b100);
        chk("midrst.flags", {zero, carry, neg, ovf}, 4'b0000);
        chk("midrst.result", result, 0);
        chk("midrst.acc", acc_out, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        acc_m = 8'h00;
        ov = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (out_valid || busy) ov++;
        end
        chk("midrst.no_result", ov, 0);
        run_op("midrst.add", 3'd0, 1'b0, 8'h01, 8'h01, 1'b0, 0, mk(8'h02, 1'b0, 1'b0));

        // Random ops against the reference model
        for (int i = 0; i < 150; i++) begin
            ro = 3'($urandom); ram = 1'($urandom); ra = 8'($urandom); rb8 = 8'($urandom);
            rclr = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 9) == 0) clr_pulse($sformatf("rnd%0d", i));
            aop = ram ? acc_m : ra;
            e = ref_op(int'(ro), int'(aop), int'(rb8));
            run_op($sformatf("rnd%0d", i), ro, ram, ra, rb8, rclr, $urandom_range(0, 2), e);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
